// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a sync FIFO and shifts them out as UART frames (start, LSB-first data, stop).
// The line is driven from a register so it never glitches on state changes.
module fifo_uart_tx #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             fifo_not_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);
    localparam int BW = $clog2(CLK_DIV);
    localparam int NW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [NW-1:0] BIT_LAST = NW'(WIDTH - 1);
    localparam logic [2:0] IDLE = 3'd0, POP = 3'd1, LOAD = 3'd2, START = 3'd3, DATA = 3'd4, STOP = 3'd5;
    logic [2:0] state;
    logic [BW-1:0] baud;
    logic [NW-1:0] bit_cnt;
    logic [WIDTH-1:0] shift;
    logic baud_end;
    assign baud_end = baud == BAUD_LAST;
    assign fifo_rd_en = state == POP;
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            baud    <= (state inside {START, DATA, STOP}) && !baud_end ? baud + 1'b1 : '0;
            case (state)
                IDLE: if (tx_en && fifo_not_empty) state <= POP;
                POP: state <= LOAD;
                // FIFO data is valid one cycle after the pop strobe
                LOAD: begin
                    shift <= fifo_data;
                    tx    <= 1'b0;
                    state <= START;
                end
                START: if (baud_end) begin
                    tx      <= shift[0];
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: if (baud_end) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    tx      <= bit_cnt == BIT_LAST ? 1'b1 : shift[1];
                    state   <= bit_cnt == BIT_LAST ? STOP : DATA;
                end
                STOP: if (baud_end) begin
                    tx_done <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed per-cycle segment tables for single frames and corner cases,
// plus a line decoder scoreboard over random words with random tx_en.
module tb_fifo_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_en = 1'b1;
    logic fifo_not_empty;
    logic [7:0] fifo_data = '0;
    logic fifo_rd_en, tx, busy, tx_done;

    fifo_uart_tx #(.WIDTH(8), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_not_empty(fifo_not_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model with registered read
    logic [7:0] mem [1024];
    int wp = 0, rp = 0, pops = 0, underflow = 0;
    assign fifo_not_empty = wp != rp;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pops = pops + 1;
            if (wp == rp) underflow = underflow + 1;
            else begin
                fifo_data <= mem[rp[9:0]];
                rp <= rp + 1;
            end
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wp[9:0]] = d;
        wp = wp + 1;
    endtask

    // line decoder: sample mid-bit, 4 clocks per bit
    logic [7:0] rx_q[$];
    logic [7:0] rsh = '0;
    logic ract = 1'b0;
    int rc = 0, ferr = 0;
    always @(negedge clk) begin
        if (rst) ract = 1'b0;
        else if (!ract) begin
            if (tx == 1'b0) begin
                ract = 1'b1;
                rc = 1;
            end
        end else begin
            if (rc == 2 && tx !== 1'b0) ferr++;
            if (rc % 4 == 2 && rc >= 6 && rc <= 34) rsh[rc/4-1] = tx;
            if (rc == 38) begin
                if (tx !== 1'b1) ferr++;
                rx_q.push_back(rsh);
            end
            if (rc == 39) ract = 1'b0;
            rc++;
        end
    end

    // expected {tx, fifo_rd_en, busy, tx_done} per cycle
    typedef struct {
        logic       en;
        int         n;
        logic [3:0] exp;
    } seg_t;
    seg_t segs[$];
    localparam logic [3:0] POPV = 4'b1110, H1 = 4'b1010, L1 = 4'b0010, DONE = 4'b1001, IDLEV = 4'b1000;

    task automatic add(input logic en, input int n, input logic [3:0] e);
        seg_t s;
        s.en = en;
        s.n = n;
        s.exp = e;
        segs.push_back(s);
    endtask

    task automatic run(input string name);
        for (int i = 0; i < segs.size(); i++) begin
            tx_en = segs[i].en;
            for (int k = 0; k < segs[i].n; k++) begin
                @(negedge clk);
                check(name, {tx, fifo_rd_en, busy, tx_done}, segs[i].exp);
            end
        end
        segs.delete();
    endtask

    logic [7:0] exp_q[$];
    int p0;

    initial begin
        // 1: reset, then idle with an empty FIFO
        repeat (3) @(negedge clk);
        check("reset_state", {tx, fifo_rd_en, busy, tx_done}, IDLEV);
        rst = 1'b0;
        add(1, 100, IDLEV);
        run("idle_empty");
        check("idle_pops", pops, 0);

        // 2: single word 0xA5 -> bits 1,0,1,0,0,1,0,1
        p0 = pops;
        push(8'hA5);
        add(1, 1, POPV); add(1, 1, H1); add(1, 4, L1);
        add(1, 4, H1); add(1, 4, L1); add(1, 4, H1); add(1, 8, L1);
        add(1, 4, H1); add(1, 4, L1); add(1, 8, H1);
        add(1, 1, DONE); add(1, 5, IDLEV);
        run("frame_a5");
        check("pops_a5", pops - p0, 1);

        // 3: back-to-back 0x00, 0xFF with 3 high cycles between frames
        p0 = pops;
        push(8'h00);
        push(8'hFF);
        add(1, 1, POPV); add(1, 1, H1); add(1, 36, L1); add(1, 4, H1);
        add(1, 1, DONE); add(1, 1, POPV); add(1, 1, H1); add(1, 4, L1);
        add(1, 36, H1); add(1, 1, DONE); add(1, 4, IDLEV);
        run("b2b_00_ff");
        check("pops_b2b", pops - p0, 2);

        // 4: tx_en drops at bit 3 of 0x3C (0,0,1,1,1,1,0,0); 0x81 waits until re-enabled
        p0 = pops;
        push(8'h3C);
        push(8'h81);
        add(1, 1, POPV); add(1, 1, H1); add(1, 12, L1); add(1, 4, H1);
        add(0, 12, H1); add(0, 8, L1); add(0, 4, H1); add(0, 1, DONE); add(0, 20, IDLEV);
        add(1, 1, POPV); add(1, 1, H1); add(1, 4, L1); add(1, 4, H1);
        add(1, 24, L1); add(1, 8, H1); add(1, 1, DONE); add(1, 3, IDLEV);
        run("en_drop_3c");
        check("pops_en_drop", pops - p0, 2);

        // 4b: tx_en drops during POP; 0xE1 = 1,0,0,0,0,1,1,1 still completes
        push(8'hE1);
        add(1, 1, POPV); add(0, 1, H1); add(0, 4, L1); add(0, 4, H1);
        add(0, 16, L1); add(0, 16, H1); add(0, 1, DONE); add(0, 3, IDLEV);
        run("en_drop_pop");

        // 5: reset in the middle of 0x55 data
        tx_en = 1'b1;
        push(8'h55);
        repeat (12) @(negedge clk);
        check("mid_bit1_tx", {tx, busy}, 2'b01);
        #2 rst = 1'b1;
        #1 check("async_rst", {tx, fifo_rd_en, busy, tx_done}, IDLEV);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("in_rst", {tx, fifo_rd_en, busy, tx_done}, IDLEV);
        end
        rst = 1'b0;
        add(1, 10, IDLEV);
        run("after_rst");
        push(8'h96);
        add(1, 1, POPV); add(1, 1, H1); add(1, 8, L1); add(1, 8, H1);
        add(1, 4, L1); add(1, 4, H1); add(1, 8, L1); add(1, 8, H1);
        add(1, 1, DONE); add(1, 3, IDLEV);
        run("frame_96");

        // 6: random words, random tx_en, decoded by the line monitor
        rx_q.delete();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            push(d);
        end
        for (int c = 0; c < 40000 && rx_q.size() < 256; c++) begin
            @(negedge clk);
            tx_en = $urandom_range(0, 9) < 7;
        end
        check("rx_count", rx_q.size(), 256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++) check("rx_byte", rx_q[i], exp_q[i]);
        repeat (10) @(negedge clk);
        check("underflow", underflow, 0);
        check("frame_err", ferr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
